// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// The arbiter FSM state encoding and the parity-type codes live here.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } uart_arb_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker.
// Searches upward from ptr with wrap and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      index,
    output logic               any
);

    int j;

    // Walk from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        grant = '0;
        index = '0;
        j     = 0;
        any   = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                index    = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_Tx serializer between NUM_REQ requesters, round-robin,
// with a busy timeout and a programmable idle gap between frames.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int Width        = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 16,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*Width-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_par_en,
    input  logic [NUM_REQ-1:0]       req_par_typ,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [Width-1:0]         tx_p_data,
    output logic                     tx_data_valid,
    output logic                     tx_par_en,
    output logic                     tx_par_typ,
    input  logic                     tx_busy,
    output logic [NUM_REQ-1:0]       done,
    output logic                     timeout_err,
    output logic [IW-1:0]            grant_id,
    output logic                     active
);

    localparam int TW       = $clog2(BUSY_TIMEOUT);
    localparam int GW       = 8;
    localparam int TO_LAST  = BUSY_TIMEOUT - 1;
    localparam int GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    uart_arb_state_e state, state_nxt;

    logic [IW-1:0]      rr_ptr;
    logic [TW-1:0]      tcnt;
    logic [GW-1:0]      gcnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               grant_en;
    logic               accept;
    logic               to_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_nxt     = state;
        grant_en      = (state == IDLE) && !tx_busy && !rst;
        accept        = grant_en && arb_any;
        req_ready     = grant_en ? arb_grant : '0;
        tx_data_valid = (state == ISSUE);
        active        = (state != IDLE);
        to_hit        = (state == WAIT_BUSY) && !tx_busy
                        && (tcnt == TW'(TO_LAST));
        unique case (state)
            IDLE:      if (accept) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)     state_nxt = WAIT_DONE;
                else if (to_hit) state_nxt = GAP;
            end
            WAIT_DONE: if (!tx_busy) state_nxt = GAP;
            GAP:       if (gcnt == GW'(GAP_LAST)) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            tx_p_data   <= '0;
            tx_par_en   <= 1'b0;
            tx_par_typ  <= 1'b0;
            grant_id    <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            done        <= '0;
            timeout_err <= to_hit;
            if (accept) begin
                tx_p_data  <= req_data[int'(arb_idx)*Width +: Width];
                tx_par_en  <= req_par_en[arb_idx];
                tx_par_typ <= req_par_typ[arb_idx];
                grant_id   <= arb_idx;
                rr_ptr     <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            end
            // Counters only run while their state persists.
            if (state == WAIT_BUSY && state_nxt == WAIT_BUSY)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
            if (state == GAP && state_nxt == GAP)
                gcnt <= gcnt + 1'b1;
            else
                gcnt <= '0;
            if (state == WAIT_DONE && !tx_busy)
                done <= NUM_REQ'(1) << grant_id;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a one-bit-per-clock UART_Tx model.
// Table-driven grant sequence plus directed parity, timeout, reset, busy cases.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_par_en;
    logic [3:0]  req_par_typ;
    logic [3:0]  req_ready;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_par_en;
    logic        tx_par_typ;
    logic        tx_busy;
    logic [3:0]  done;
    logic        timeout_err;
    logic [1:0]  grant_id;
    logic        active;

    logic        busy_m;
    logic        tx_out;
    logic        hold_busy;
    logic        kill_busy;
    logic [10:0] sh;
    logic [3:0]  bcnt;
    logic        cap_bits[$];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign tx_busy = (busy_m | hold_busy) & ~kill_busy;

    uart_tx_arbiter #(
        .NUM_REQ(4), .Width(8), .GAP_CYCLES(2), .BUSY_TIMEOUT(16)
    ) dut (
        .CLK(CLK), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_typ(req_par_typ),
        .req_ready(req_ready), .tx_p_data(tx_p_data),
        .tx_data_valid(tx_data_valid), .tx_par_en(tx_par_en),
        .tx_par_typ(tx_par_typ), .tx_busy(tx_busy), .done(done),
        .timeout_err(timeout_err), .grant_id(grant_id), .active(active)
    );

    function automatic logic [10:0] mk_frame(logic [7:0] d, logic pe, logic pt);
        if (pe) return {1'b1, (^d) ^ pt, d, 1'b0};
        return {2'b11, d, 1'b0};
    endfunction

    // UART_Tx stand-in: latches on Data_valid, one bit per clock.
    always @(posedge CLK) begin
        if (rst) begin
            busy_m <= 1'b0;
            tx_out <= 1'b1;
            bcnt   <= '0;
            sh     <= '0;
        end else if (!busy_m) begin
            if (tx_data_valid && !kill_busy) begin
                busy_m <= 1'b1;
                tx_out <= 1'b0;
                sh     <= mk_frame(tx_p_data, tx_par_en, tx_par_typ) >> 1;
                bcnt   <= tx_par_en ? 4'd10 : 4'd9;
            end
        end else if (bcnt == 0) begin
            busy_m <= 1'b0;
            tx_out <= 1'b1;
        end else begin
            tx_out <= sh[0];
            sh     <= sh >> 1;
            bcnt   <= bcnt - 1'b1;
        end
    end

    always @(negedge CLK) if (busy_m) cap_bits.push_back(tx_out);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (active !== 1'b0 && n < 100);
        chk("wait_idle_bound", 32'(n < 100), 1);
    endtask

    task automatic run_frame(input string nm, input logic [3:0] v,
                             input logic [3:0] er, input logic [1:0] eid,
                             input logic [7:0] ed, input logic pe,
                             input logic pt, input logic pbit,
                             input logic flip);
        logic [10:0] ef;
        logic [10:0] got;
        int len;
        int n;
        wait_idle();
        cap_bits.delete();
        req_valid = v;
        #1;
        chk({nm, ".ready"}, 32'(req_ready), 32'(er));
        @(negedge CLK);
        req_valid = '0;
        if (flip) req_par_typ = ~req_par_typ;
        #1;
        chk({nm, ".dv"}, 32'(tx_data_valid), 1);
        chk({nm, ".id"}, 32'(grant_id), 32'(eid));
        chk({nm, ".data"}, 32'(tx_p_data), 32'(ed));
        chk({nm, ".par"}, 32'({tx_par_en, tx_par_typ}), 32'({pe, pt}));
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (done === 4'b0 && timeout_err !== 1'b1 && n < 200);
        chk({nm, ".done"}, 32'(done), 32'(4'b0001 << eid));
        chk({nm, ".no_to"}, 32'(timeout_err), 0);
        chk({nm, ".par_hold"}, 32'({tx_par_en, tx_par_typ}), 32'({pe, pt}));
        if (pe) begin
            ef  = {1'b1, pbit, ed, 1'b0};
            len = 11;
        end else begin
            ef  = {2'b01, ed, 1'b0};
            len = 10;
        end
        got = '0;
        for (int i = 0; i < cap_bits.size() && i < 11; i++) got[i] = cap_bits[i];
        chk({nm, ".nbits"}, 32'(cap_bits.size()), 32'(len));
        chk({nm, ".frame"}, 32'(got), 32'(ef));
        chk({nm, ".gap0"}, 32'(active), 1);
        @(negedge CLK);
        chk({nm, ".gap1"}, 32'({active, done}), 32'({1'b1, 4'b0}));
        @(negedge CLK);
        chk({nm, ".gap_end"}, 32'(active), 0);
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [1:0] id;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n;
        int bad;
        tbl[0] = '{4'hF, 4'b0001, 2'd0, 8'h11};
        tbl[1] = '{4'hF, 4'b0010, 2'd1, 8'h22};
        tbl[2] = '{4'hF, 4'b0100, 2'd2, 8'h33};
        tbl[3] = '{4'hF, 4'b1000, 2'd3, 8'h44};
        tbl[4] = '{4'hF, 4'b0001, 2'd0, 8'h11};
        tbl[5] = '{4'b1001, 4'b1000, 2'd3, 8'h44};
        tbl[6] = '{4'b0110, 4'b0010, 2'd1, 8'h22};
        tbl[7] = '{4'b0011, 4'b0001, 2'd0, 8'h11};
        tbl[8] = '{4'b0100, 4'b0100, 2'd2, 8'h33};
        tbl[9] = '{4'b0001, 4'b0001, 2'd0, 8'h11};

        rst         = 1'b1;
        req_valid   = '0;
        req_data    = 32'h4433_2281;
        req_par_en  = '0;
        req_par_typ = '0;
        hold_busy   = 1'b0;
        kill_busy   = 1'b0;
        do_reset();
        #1;
        chk("reset_outs", 32'({req_ready, tx_p_data, tx_data_valid, tx_par_en,
                               tx_par_typ, done, timeout_err, grant_id, active}), 0);

        run_frame("single", 4'b0001, 4'b0001, 2'd0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);

        req_data = 32'h4433_2211;
        do_reset();
        foreach (tbl[i])
            run_frame($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].ready,
                      tbl[i].id, tbl[i].data, 1'b0, 1'b0, 1'b0, 1'b0);

        req_data    = 32'h447F_7F11;
        req_par_en  = 4'b0110;
        req_par_typ = {1'b0, PAR_ODD, PAR_EVEN, 1'b0};
        run_frame("par_even", 4'b0010, 4'b0010, 2'd1, 8'h7F, 1'b1, PAR_EVEN, 1'b1, 1'b1);
        req_par_typ = {1'b0, PAR_ODD, PAR_EVEN, 1'b0};
        run_frame("par_odd", 4'b0100, 4'b0100, 2'd2, 8'h7F, 1'b1, PAR_ODD, 1'b0, 1'b1);
        req_data    = 32'h4433_2211;
        req_par_en  = '0;
        req_par_typ = '0;

        wait_idle();
        kill_busy = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("to.ready", 32'(req_ready), 32'(4'b1000));
        @(negedge CLK);
        req_valid = '0;
        chk("to.dv", 32'(tx_data_valid), 1);
        n   = 0;
        bad = 0;
        do begin
            @(negedge CLK);
            n++;
            if (done !== 4'b0) bad++;
        end while (timeout_err !== 1'b1 && n < 40);
        chk("to.latency", 32'(n), 17);
        chk("to.no_done", 32'(bad), 0);
        @(negedge CLK);
        chk("to.pulse", 32'({timeout_err, done}), 0);
        kill_busy = 1'b0;
        run_frame("after_to", 4'b0001, 4'b0001, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_idle();
        req_valid = 4'b0010;
        @(negedge CLK);
        req_valid = '0;
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("rst.busy_seen", 32'(tx_busy), 1);
        repeat (2) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        chk("rst.outs", 32'({req_ready, tx_p_data, tx_data_valid, tx_par_en,
                             tx_par_typ, done, timeout_err, grant_id, active}), 0);
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done !== 4'b0) bad++;
        end
        chk("rst.no_done", 32'(bad), 0);
        run_frame("rst_ptr", 4'b1001, 4'b0001, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        wait_idle();
        hold_busy = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("hold.ready0", 32'(req_ready), 0);
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (req_ready !== 4'b0 || active !== 1'b0) bad++;
        end
        chk("hold.blocked", 32'(bad), 0);
        hold_busy = 1'b0;
        #1;
        chk("hold.ready1", 32'(req_ready), 32'(4'b0100));
        @(negedge CLK);
        req_valid = '0;
        chk("hold.grant", 32'({tx_data_valid, grant_id}), 32'({1'b1, 2'd2}));
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (done === 4'b0 && n < 200);
        chk("hold.done", 32'(done), 32'(4'b0100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
